// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle control sequencer: IR field layout,
// opcode map, ALU operation codes and FSM state encoding.
package cpu_ctrl_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_MUL  = 4'd5;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_E1    = 4'd5;
    localparam logic [3:0] S_E2    = 4'd6;
    localparam logic [3:0] S_E3    = 4'd7;
    localparam logic [3:0] S_E4    = 4'd8;
    localparam logic [3:0] S_E5    = 4'd9;
    localparam logic [3:0] S_HALT  = 4'd10;
    localparam logic [3:0] S_FAULT = 4'd11;

    // Register-register and immediate forms share an ALU code per operation.
    function automatic logic [3:0] alu_code_of(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            default:         return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns the Ra/Rb/Rc IR fields plus group selects into one-hot GP register
// load/drive strobes; a base-address request on R0 drives zero via BAout.
module reg_select_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin_en,
    input  logic        Rout_en,
    input  logic        BAout_req,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        BAout
);

    logic [3:0]  idx;
    logic [15:0] onehot;

    always_comb begin
        idx = 4'd0;
        if (Gra)      idx = ra;
        else if (Grb) idx = rb;
        else if (Grc) idx = rc;
        onehot = 16'h0001 << idx;
        BAout  = BAout_req && (idx == 4'd0);
        Rin    = Rin_en ? onehot : 16'h0000;
        Rout   = ((Rout_en || BAout_req) && !BAout) ? onehot : 16'h0000;
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit for the single-bus datapath: fetch T0..T3, execute
// E1..E5, memory handshake with timeout, Moore strobe decode from state and IR.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [31:0]         ir,
    input  logic                con_ff,
    input  logic                mem_done,
    output logic [15:0]         Rin,
    output logic [15:0]         Rout,
    output logic                BAout,
    output logic                PCin,
    output logic                PCout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                HIin,
    output logic                LOin,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                Cout,
    output logic                IncPC,
    output logic                CONin,
    output logic                Read,
    output logic                Write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                fault
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic [4:0]       opc;
    logic             is_alu3, is_imm, is_mem;
    logic             in_wait, timeout;
    logic             gra, grb, grc, rin_en, rout_en, baout_req;
    logic [3:0]       alu_code;
    logic             ir_unused;

    assign opc       = ir[OPC_HI:OPC_LO];
    assign ir_unused = ^ir[RC_LO-1:0];
    assign is_alu3   = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    assign is_imm    = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
    assign is_mem    = (opc == OP_LD) || (opc == OP_ST);

    assign in_wait = (state_q == S_T2) || (state_q == S_E4 && opc == OP_LD) ||
                     (state_q == S_E5 && opc == OP_ST);
    assign timeout = in_wait && !mem_done && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Wait counter is zero outside wait states, so every wait starts from zero.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        cnt_d   = (in_wait && !mem_done) ? cnt_q + CNT_W'(1) : '0;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   if (mem_done) state_d = S_T3;
            S_T3:   state_d = S_E1;
            S_E1: begin
                if (opc == OP_NOP || opc == OP_JR) state_d = S_T0;
                else if (opc == OP_HALT) state_d = S_HALT;
                else if (is_alu3 || is_imm || is_mem || opc == OP_MUL || opc == OP_BR) state_d = S_E2;
                else begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end
            end
            S_E2:   state_d = S_E3;
            S_E3:   state_d = (is_alu3 || is_imm) ? S_T0 : S_E4;
            S_E4: begin
                if (opc == OP_ST) state_d = S_E5;
                else if (opc == OP_LD) begin
                    if (mem_done) state_d = S_E5;
                end else state_d = S_T0;
            end
            S_E5: begin
                if (opc == OP_LD || mem_done) state_d = S_T0;
            end
            default: state_d = state_q;
        endcase
        if (timeout) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cnt_d   = '0;
        end
    end

    always_comb begin
        {PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, LOin} = 10'b0;
        {Zhighout, Zlowout, Cout, IncPC, CONin, Read, Write} = 7'b0;
        {gra, grb, grc, rin_en, rout_en, baout_req} = 6'b0;
        alu_code = ALU_NONE;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; end
            S_T2: begin Read = 1'b1; MDRin = mem_done; end
            S_T3: begin MDRout = 1'b1; IRin = 1'b1; end
            S_E1: begin
                if (is_alu3 || is_imm) begin grb = 1'b1; rout_en = 1'b1; Yin = 1'b1; end
                else if (opc == OP_MUL) begin gra = 1'b1; rout_en = 1'b1; Yin = 1'b1; end
                else if (is_mem) begin grb = 1'b1; baout_req = 1'b1; Yin = 1'b1; end
                else if (opc == OP_BR) begin gra = 1'b1; rout_en = 1'b1; CONin = 1'b1; end
                else if (opc == OP_JR) begin gra = 1'b1; rout_en = 1'b1; PCin = 1'b1; end
            end
            S_E2: begin
                if (is_alu3) begin grc = 1'b1; rout_en = 1'b1; Zin = 1'b1; alu_code = alu_code_of(opc); end
                else if (is_imm) begin Cout = 1'b1; Zin = 1'b1; alu_code = alu_code_of(opc); end
                else if (opc == OP_MUL) begin grb = 1'b1; rout_en = 1'b1; Zin = 1'b1; alu_code = ALU_MUL; end
                else if (is_mem) begin Cout = 1'b1; Zin = 1'b1; alu_code = ALU_ADD; end
                else if (opc == OP_BR) begin PCout = 1'b1; Yin = 1'b1; end
            end
            S_E3: begin
                if (is_alu3 || is_imm) begin Zlowout = 1'b1; gra = 1'b1; rin_en = 1'b1; end
                else if (opc == OP_MUL) begin Zlowout = 1'b1; LOin = 1'b1; end
                else if (is_mem) begin Zlowout = 1'b1; MARin = 1'b1; end
                else if (opc == OP_BR) begin Cout = 1'b1; Zin = 1'b1; alu_code = ALU_ADD; end
            end
            S_E4: begin
                if (opc == OP_MUL) begin Zhighout = 1'b1; HIin = 1'b1; end
                else if (opc == OP_LD) begin Read = 1'b1; MDRin = mem_done; end
                else if (opc == OP_ST) begin gra = 1'b1; rout_en = 1'b1; MDRin = 1'b1; end
                else if (opc == OP_BR) begin Zlowout = 1'b1; PCin = con_ff; end
            end
            S_E5: begin
                if (opc == OP_LD) begin MDRout = 1'b1; gra = 1'b1; rin_en = 1'b1; end
                else if (opc == OP_ST) Write = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decoder u_regsel (
        .ra        (ir[RA_HI:RA_LO]),
        .rb        (ir[RB_HI:RB_LO]),
        .rc        (ir[RC_HI:RC_LO]),
        .Gra       (gra),
        .Grb       (grb),
        .Grc       (grc),
        .Rin_en    (rin_en),
        .Rout_en   (rout_en),
        .BAout_req (baout_req),
        .Rin       (Rin),
        .Rout      (Rout),
        .BAout     (BAout)
    );

    assign alu_op = ALU_OP_W'(alu_code);
    assign run    = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
    assign fault  = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe traces for fetch and
// each instruction class, memory timeout, illegal opcode, HALT and async reset.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        clr, start, con_ff, mem_done;
    logic [31:0] ir;
    logic [15:0] Rin, Rout;
    logic        BAout, PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, LOin;
    logic        Zhighout, Zlowout, Cout, IncPC, CONin, Read, Write, run, fault;
    logic [3:0]  alu_op;
    int          checks = 0;
    int          errors = 0;

    localparam logic [19:0] PCIN  = 20'h80000, PCOUT = 20'h40000, IRIN  = 20'h20000, YIN   = 20'h10000;
    localparam logic [19:0] ZIN   = 20'h08000, MARIN = 20'h04000, MDRIN = 20'h02000, MDROUT = 20'h01000;
    localparam logic [19:0] HIIN  = 20'h00800, LOIN  = 20'h00400, ZHI   = 20'h00200, ZLO   = 20'h00100;
    localparam logic [19:0] COUT  = 20'h00080, INCPC = 20'h00040, CONIN = 20'h00020, READ  = 20'h00010;
    localparam logic [19:0] WRITE = 20'h00008, BAOUT = 20'h00004, RUN   = 20'h00002, FLT   = 20'h00001;
    localparam logic [19:0] FETCH0 = PCOUT | MARIN | INCPC | ZIN | RUN;
    localparam logic [15:0] Z16 = 16'h0000;
    localparam logic [3:0]  Z4  = 4'h0;

    always #5 clk = ~clk;

    control_sequencer #(.MEM_TIMEOUT(16), .ALU_OP_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .con_ff(con_ff), .mem_done(mem_done),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .PCin(PCin), .PCout(PCout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin),
        .LOin(LOin), .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout), .IncPC(IncPC),
        .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .fault(fault)
    );

    function automatic logic [55:0] obs();
        return {PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, LOin, Zhighout, Zlowout,
                Cout, IncPC, CONin, Read, Write, BAout, run, fault, Rin, Rout, alu_op};
    endfunction

    function automatic logic [55:0] ev(input logic [19:0] s, input logic [15:0] ri,
                                       input logic [15:0] ro, input logic [3:0] a);
        return {s, ri, ro, a};
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0010};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clr = 1'b0; start = 1'b0; mem_done = 1'b0; con_ff = 1'b0;
        @(posedge clk);
        #2;
        clr = 1'b1;
    endtask

    // Runs a fetch with a one-cycle memory read; returns positioned in E1.
    task automatic do_fetch(input logic [31:0] instr);
        ir = instr;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        mem_done = 1'b1;
        cyc();
        mem_done = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 1'b1; mem_done = 1'b1; con_ff = 1'b1; ir = enc(OP_ADD, 4'd1, 4'd1, 4'd1);
        #1;
        checks++;
        if (obs() !== 56'h0) begin errors++; $display("FAIL reset_initial: got %h expected %h", obs(), 56'h0); end
        @(posedge clk); @(posedge clk); #2;
        checks++;
        if (obs() !== 56'h0) begin errors++; $display("FAIL reset_held: got %h expected %h", obs(), 56'h0); end
        start = 1'b0; mem_done = 1'b0; con_ff = 1'b0;
        clr = 1'b1;
        cyc(); #1;
        checks++;
        if (obs() !== 56'h0) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs(), 56'h0); end
    endtask

    task automatic test_add();
        logic [55:0] e [9];
        logic [8:0]  md;
        do_reset();
        ir = enc(OP_ADD, 4'd3, 4'd1, 4'd2);
        start = 1'b1;
        md = 9'b000101000;
        e = '{ev(FETCH0, Z16, Z16, Z4), ev(ZLO | PCIN | RUN, Z16, Z16, Z4), ev(READ | RUN, Z16, Z16, Z4),
              ev(READ | MDRIN | RUN, Z16, Z16, Z4), ev(MDROUT | IRIN | RUN, Z16, Z16, Z4),
              ev(YIN | RUN, Z16, 16'h0002, Z4), ev(ZIN | RUN, Z16, 16'h0004, 4'd1),
              ev(ZLO | RUN, 16'h0008, Z16, Z4), ev(FETCH0, Z16, Z16, Z4)};
        for (int i = 0; i < 9; i++) begin
            cyc();
            start = 1'b0;
            mem_done = md[i];
            #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL add_step%0d: got %h expected %h", i, obs(), e[i]); end
        end
        mem_done = 1'b0;
    endtask

    task automatic test_load();
        logic [55:0] e [8];
        logic [7:0]  md;
        do_reset();
        do_fetch(enc(OP_LD, 4'd4, 4'd0, 4'd0));
        md = 8'b00100000;
        e = '{ev(YIN | BAOUT | RUN, Z16, Z16, Z4), ev(COUT | ZIN | RUN, Z16, Z16, 4'd1),
              ev(ZLO | MARIN | RUN, Z16, Z16, Z4), ev(READ | RUN, Z16, Z16, Z4), ev(READ | RUN, Z16, Z16, Z4),
              ev(READ | MDRIN | RUN, Z16, Z16, Z4), ev(MDROUT | RUN, 16'h0010, Z16, Z4), ev(FETCH0, Z16, Z16, Z4)};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            mem_done = md[i];
            #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL ld_step%0d: got %h expected %h", i, obs(), e[i]); end
        end
        mem_done = 1'b0;
    endtask

    task automatic test_branch();
        logic [55:0] e [5];
        for (int cf = 0; cf < 2; cf++) begin
            do_reset();
            con_ff = (cf == 1);
            do_fetch(enc(OP_BR, 4'd5, 4'd0, 4'd0));
            e = '{ev(CONIN | RUN, Z16, 16'h0020, Z4), ev(PCOUT | YIN | RUN, Z16, Z16, Z4),
                  ev(COUT | ZIN | RUN, Z16, Z16, 4'd1),
                  ev(ZLO | RUN | ((cf == 1) ? PCIN : 20'h0), Z16, Z16, Z4), ev(FETCH0, Z16, Z16, Z4)};
            for (int i = 0; i < 5; i++) begin
                if (i > 0) cyc();
                #1;
                checks++;
                if (obs() !== e[i]) begin
                    errors++;
                    $display("FAIL br_con%0d_step%0d: got %h expected %h", cf, i, obs(), e[i]);
                end
            end
        end
        con_ff = 1'b0;
    endtask

    task automatic test_mul();
        logic [55:0] e [5];
        do_reset();
        do_fetch(enc(OP_MUL, 4'd6, 4'd7, 4'd0));
        e = '{ev(YIN | RUN, Z16, 16'h0040, Z4), ev(ZIN | RUN, Z16, 16'h0080, 4'd5),
              ev(ZLO | LOIN | RUN, Z16, Z16, Z4), ev(ZHI | HIIN | RUN, Z16, Z16, Z4), ev(FETCH0, Z16, Z16, Z4)};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL mul_step%0d: got %h expected %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_fetch_timeout();
        int n;
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        #1;
        n = 0;
        while (Read === 1'b1 && n < 40) begin
            n++;
            cyc();
            #1;
        end
        checks++;
        if (n != 16) begin errors++; $display("FAIL timeout_wait_cycles: got %0d expected %0d", n, 16); end
        checks++;
        if (obs() !== ev(FLT, Z16, Z16, Z4)) begin
            errors++; $display("FAIL timeout_fault: got %h expected %h", obs(), ev(FLT, Z16, Z16, Z4));
        end
        start = 1'b1;
        cyc();
        cyc();
        start = 1'b0;
        #1;
        checks++;
        if (obs() !== ev(FLT, Z16, Z16, Z4)) begin
            errors++; $display("FAIL timeout_sticky: got %h expected %h", obs(), ev(FLT, Z16, Z16, Z4));
        end
    endtask

    task automatic test_illegal();
        do_reset();
        do_fetch(enc(5'b11111, 4'd1, 4'd2, 4'd3));
        cyc();
        #1;
        checks++;
        if (obs() !== ev(FLT, Z16, Z16, Z4)) begin
            errors++; $display("FAIL illegal_opcode: got %h expected %h", obs(), ev(FLT, Z16, Z16, Z4));
        end
    endtask

    task automatic test_halt();
        do_reset();
        do_fetch(enc(OP_HALT, 4'd0, 4'd0, 4'd0));
        cyc();
        #1;
        checks++;
        if (obs() !== 56'h0) begin errors++; $display("FAIL halt_state: got %h expected %h", obs(), 56'h0); end
        start = 1'b1;
        cyc();
        cyc();
        #1;
        checks++;
        if (obs() !== 56'h0) begin errors++; $display("FAIL halt_ignores_start: got %h expected %h", obs(), 56'h0); end
        start = 1'b0;
    endtask

    task automatic test_reset_during_store();
        logic [55:0] e [6];
        do_reset();
        do_fetch(enc(OP_ST, 4'd3, 4'd2, 4'd0));
        e = '{ev(YIN | RUN, Z16, 16'h0004, Z4), ev(COUT | ZIN | RUN, Z16, Z16, 4'd1),
              ev(ZLO | MARIN | RUN, Z16, Z16, Z4), ev(MDRIN | RUN, Z16, 16'h0008, Z4),
              ev(WRITE | RUN, Z16, Z16, Z4), ev(WRITE | RUN, Z16, Z16, Z4)};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            #1;
            checks++;
            if (obs() !== e[i]) begin errors++; $display("FAIL st_step%0d: got %h expected %h", i, obs(), e[i]); end
        end
        #1;
        clr = 1'b0;
        #1;
        checks++;
        if (obs() !== 56'h0) begin errors++; $display("FAIL st_async_clear: got %h expected %h", obs(), 56'h0); end
        cyc();
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            checks++;
            if (obs() !== 56'h0) begin errors++; $display("FAIL st_idle_after_reset%0d: got %h expected %h", i, obs(), 56'h0); end
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        checks++;
        if (obs() !== ev(FETCH0, Z16, Z16, Z4)) begin
            errors++; $display("FAIL st_restart: got %h expected %h", obs(), ev(FETCH0, Z16, Z16, Z4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_mul();
        test_fetch_timeout();
        test_illegal();
        test_halt();
        test_reset_during_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
